// File: rtl/square_iter.sv
// ----------------------------------------------------------------------------
// square_iter
// Iterative shift-and-add squarer. Accepts an unsigned root on a start request
// in IDLE and, after a fixed WIDTH-step run, presents root*root at 2*WIDTH
// bits. It regenerates the radicand from a square-root result so convergence
// can be confirmed.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   root     in   [WIDTH-1:0]   operand, captured on the accepted start edge
//   n_ref    in   [WIDTH-1:0]   radicand under test (bound check build only)
//   busy     out  operation in progress, including the DONE cycle
//   done     out  one-cycle pulse, square is new in that cycle
//   square   out  [2*WIDTH-1:0] last completed result
//   in_bound out  root is the floor square root of n_ref (bound check build)
//
// Build option: define SQUARE_BOUND_CHECK_EN to add the floor-root bound
// check; otherwise n_ref is ignored and in_bound is tied low.
// ----------------------------------------------------------------------------
module square_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     root,
    input  logic [WIDTH-1:0]     n_ref,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   square,
    output logic                 in_bound
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic [2*WIDTH-1:0] SQ_ZERO  = {(2*WIDTH){1'b0}};
    localparam logic [WIDTH-1:0]   RT_ZERO  = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic                 last_step_s;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   square_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One multiply step: conditionally add the shifted multiplicand.
    // The sum cannot overflow 2*WIDTH bits since (2^W-1)^2 < 2^(2W).
    always_comb begin
        acc_step_s  = acc_r;
        last_step_s = (state_r == RUN) && (cnt_r == CNT_LAST);
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
    end

    // Datapath registers: load on accept, shift/accumulate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= SQ_ZERO;
            mplier_r <= RT_ZERO;
            acc_r    <= SQ_ZERO;
            cnt_r    <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= {RT_ZERO, root};
                        mplier_r <= root;
                        acc_r    <= SQ_ZERO;
                        cnt_r    <= CNT_ZERO;
                    end
                end
                RUN: begin
                    acc_r    <= acc_step_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Registered handshake and result; square is written with the last add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            square_r <= SQ_ZERO;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
            if (last_step_s) begin
                square_r <= acc_step_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign square = square_r;

`ifdef SQUARE_BOUND_CHECK_EN
    logic [WIDTH-1:0]   root_r;
    logic [WIDTH-1:0]   n_ref_r;
    logic [2*WIDTH:0]   bound_hi_s;
    logic               in_bound_s;
    logic               in_bound_r;

    // Operand copies for the bound check; mplier is consumed by the shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_r  <= RT_ZERO;
            n_ref_r <= RT_ZERO;
        end else if ((state_r == IDLE) && start) begin
            root_r  <= root;
            n_ref_r <= n_ref;
        end
    end

    // (R+1)^2 = R^2 + 2R + 1, computed one bit wider so R = 2^W-1 fits.
    always_comb begin
        bound_hi_s = {1'b0, acc_step_s} + {{WIDTH{1'b0}}, root_r, 1'b1};
        in_bound_s = (acc_step_s <= {RT_ZERO, n_ref_r}) &&
                     ({1'b0, RT_ZERO, n_ref_r} < bound_hi_s);
    end

    // Bound flag registered alongside square.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_bound_r <= 1'b0;
        end else if (last_step_s) begin
            in_bound_r <= in_bound_s;
        end
    end

    assign in_bound = in_bound_r;
`else
    logic unused_n_ref_s;
    assign unused_n_ref_s = ^n_ref;
    assign in_bound       = 1'b0;
`endif

endmodule

// File: tb/tb_square_iter.sv
module tb_square_iter;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   root;
    logic [W-1:0]   n_ref;
    logic           busy;
    logic           done;
    logic [2*W-1:0] square;
    logic           in_bound;

    int unsigned    sq_q[$];
    bit             ib_q[$];
    int             n_pass = 0;
    int             n_chk  = 0;

    square_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .root     (root),
        .n_ref    (n_ref),
        .busy     (busy),
        .done     (done),
        .square   (square),
        .in_bound (in_bound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit exp_bound(input int unsigned r, input int unsigned n);
`ifdef SQUARE_BOUND_CHECK_EN
        return (r * r <= n) && (n < (r + 1) * (r + 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_exp(input int unsigned r, input int unsigned n);
        sq_q.push_back(r * r);
        ib_q.push_back(exp_bound(r, n));
    endtask

    // Wait (bounded) for done; check latency and the scoreboard entry.
    task automatic wait_done(input int exp_lat, output int bc);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        bc  = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (busy === 1'b1) bc++;
            if (done === 1'b1) got = 1'b1;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("latency", lat, exp_lat);
            check("queue_nonempty", sq_q.size() > 0, 1);
            if (sq_q.size() > 0) begin
                check("square", square, sq_q.pop_front());
                check("in_bound", in_bound, ib_q.pop_front());
            end
        end
    endtask

    task automatic run_op(input int unsigned r, input int unsigned n);
        int bc;
        int bc_tot;
        root  = W'(r);
        n_ref = W'(n);
        push_exp(r, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        root  = W'($urandom);
        n_ref = W'($urandom);
        bc_tot = (busy === 1'b1) ? 1 : 0;
        wait_done(W, bc);
        bc_tot += bc;
        check("busy_cycles", bc_tot, W + 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        int bc;
        int dcount;
        rst_n = 1'b0;
        start = 1'b0;
        root  = '0;
        n_ref = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_square", square, 0);
        check("rst_in_bound", in_bound, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic operands, including both extremes.
        run_op(0, 0);
        run_op(15, 0);
        run_op(255, 0);

        // Starts during RUN and DONE are ignored; accept at E10 works.
        root  = 8'd200;
        n_ref = 8'd0;
        push_exp(200, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1;
        root  = 8'd3;
        tick();
        start = 1'b0;
        root  = 8'd77;
        wait_done(4, bc);
        start = 1'b1;
        root  = 8'd3;
        push_exp(3, 0);
        tick();
        check("start_at_done_ignored", busy, 0);
        tick();
        start = 1'b0;
        check("accept_at_e10", busy, 1);
        wait_done(8, bc);
        tick();
        check("idle_after_e10_op", busy, 0);

        // start held high: one result every WIDTH+2 cycles.
        root  = 8'd12;
        start = 1'b1;
        push_exp(12, 0);
        push_exp(12, 0);
        push_exp(12, 0);
        tick();
        wait_done(8, bc);
        wait_done(10, bc);
        wait_done(10, bc);
        start = 1'b0;
        tick();
        tick();
        check("held_stop_idle", busy, 0);

        // Reset mid-operation aborts at once.
        root  = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_square", square, 0);
        check("abort_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("no_done_after_abort", dcount, 0);
        check("idle_after_abort", busy, 0);
        run_op(7, 0);

        // Bound check (expected 0 when the option is not built in).
        run_op(15, 230);
        run_op(16, 230);
        run_op(14, 230);
        run_op(15, 255);

        check("queue_drained", sq_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/square_iter.md
# square_iter

Iterative shift-and-add squarer: it takes an unsigned root `R` and returns `R*R` at full width after a fixed `WIDTH`-cycle run. It is the inverse companion to the Newton-iteration square-root datapath. The square-root result register feeds `root`, and the squarer regenerates the radicand so the bench and the system controller can confirm convergence. A start/busy/done handshake makes it safe to share with the square-root load sequencing.

## Interface
- `WIDTH`, default 8: root width; square width is `2*WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `root`  in  `WIDTH`  unsigned operand; captured on the accepted `start` edge.
- `n_ref`  in  `WIDTH`  radicand under test (used only with `SQUARE_BOUND_CHECK_EN`).
- `busy`  out  1  operation in progress, including the DONE cycle.
- `done`  out  1  one-cycle pulse; `square` is valid and new in that cycle.
- `square`  out  `2*WIDTH`  last completed result; holds until the next completion.
- `in_bound`  out  1  `root` is the exact floor square root of `n_ref` (macro only; otherwise tied 0).

## Operation
- Internal registers:
  - `mcand`: `2*WIDTH` bits, zero-extended root, shifted left one bit per step.
  - `mplier`: `WIDTH` bits, the root, shifted right one bit per step.
  - `acc`: `2*WIDTH` bits.
  - `cnt`: `$clog2(WIDTH+1)` bits.
- FSM states and transitions:
  - IDLE → RUN on `start`=1.
  - RUN → RUN while `cnt` < `WIDTH`-1.
  - RUN → DONE when the step with `cnt`=`WIDTH`-1 completes.
  - DONE → IDLE unconditionally.
- Accept (IDLE, `start`=1):
  - `mcand` ← {0, `root`}, `mplier` ← `root`, `acc` ← 0, `cnt` ← 0.
- Each RUN step:
  - If `mplier[0]`, `acc` ← `acc` + `mcand`. The addition is `2*WIDTH` wide and never overflows, since the maximum is (2^W−1)^2.
  - `mcand` ← `mcand`<<1, `mplier` ← `mplier`>>1, `cnt`++.
- On the final step, `square` ← the final accumulated value, written in the same edge as the last add.
- `start` while `busy`=1 is ignored: no queueing, and the operand in flight is unchanged. `root` changes after acceptance have no effect.
- `start` held high continuously starts a new operation on every IDLE cycle, i.e. one result every `WIDTH`+2 cycles.
- No early termination: `root`=0 still takes the full run.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `busy`=0, `done`=0, `in_bound`=0, `square`=0.
  - `acc`, `mcand`, `mplier`, `cnt` all 0.
- Let E0 be the edge that accepts `start`. The RUN steps occur on edges E1..E`WIDTH`.
- `busy`=1 from after E0 through the cycle after E`WIDTH`.
- `done`=1 for exactly the one cycle after E`WIDTH`; `square` is updated at that same edge.
- At E`WIDTH`+1 the FSM returns to IDLE with `busy`=0. A `start` present at E`WIDTH`+1 is not accepted; the earliest next accept is E`WIDTH`+2.
- Latency from start edge to `done` is `WIDTH` cycles; for `WIDTH`=8, `done` is seen 8 cycles after E0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation aborts it at once:
  - `square` returns to 0.
  - No `done` is produced.
  - After release, the block sits in IDLE.

## Configuration
- `SQUARE_BOUND_CHECK_EN` defined:
  - On the final step, the block also computes `acc_next` + 2·`root` + 1, which is (R+1)^2 in `2*WIDTH`+1 bits.
  - `in_bound` is registered alongside `square`: 1 iff `square` ≤ `n_ref` < (R+1)^2.
  - `n_ref` is sampled at E0 with `root`.
  - `in_bound` holds until the next completion and resets to 0.
- Not defined:
  - `n_ref` is unused.
  - `in_bound` is constant 0.
  - No extra adder is synthesised.

## Test plan
- `root`=0, 15, 255 (`WIDTH`=8), one start each → `done` exactly 8 cycles after E0; `square`=0, 225, 65025 respectively; `busy` high for 9 cycles.
- Accept `root`=200; pulse `start` with `root`=3 at E4 and at the DONE cycle → both ignored; `square`=40000; next accept no earlier than E10.
- `start` held high with `root`=12 → `done` pulses every 10 cycles, each with `square`=144.
- Accept `root`=100; assert `rst_n`=0 at E5 → immediately `busy`=0, `square`=0; no `done` follows after release; a new start with `root`=7 gives 49.
- Macro on, `n_ref`=230: `root`=15 → `in_bound`=1; `root`=16 → 0; `root`=14 → 0. Then `n_ref`=255, `root`=15 → 1.
- Macro off, `n_ref`=230, `root`=15 → `in_bound`=0 and `square`=225.
